rr_arbiter: RTL
===============

# rr_arbiter

Round-robin, packet-locking arbiter that shares one downstream valid/ready channel among `Inputs` requesters. It emits a registered one-hot `grant` that drives the `sel` inputs of the one-hot AND-OR data mux directly. It also returns per-requester `req_ready`. It sits in front of shared resources such as the memory port and the writeback bus, which are contended by fetch, load/store and other masters.

## Interface
Parameters:
- `Inputs`, 4: number of requesters; must be ≥ 1.
- `IdxWidth`, `(Inputs > 1) ? $clog2(Inputs) : 1`: width of `grant_index`; derived, not overridden.

Ports:
- `clk`  in  1  single clock; all state updates on rising edge.
- `rst`  in  1  reset, synchronous and active-high.
- `req_valid[Inputs]`  in  1 each  requester i has a beat pending.
- `req_last[Inputs]`  in  1 each  pending beat is the final beat of requester i's packet.
- `req_ready[Inputs]`  out  1 each  beat from requester i is accepted this cycle.
- `grant[Inputs]`  out  1 each  one-hot owner of the channel; drives the data mux `sel`.
- `grant_index`  out  IdxWidth  binary index of the owner; 0 when idle.
- `out_valid`  out  1  downstream valid.
- `out_last`  out  1  downstream last.
- `out_ready`  in  1  downstream ready.

## Operation
- There are two states, declared as `arb_state_e`:
  - `ARB_IDLE`: no grant.
  - `ARB_LOCKED`: exactly one `grant[g]` is high.
- Round-robin pointer `ptr` (IdxWidth bits):
  - Priority search starts at `ptr` and wraps modulo `Inputs`.
  - On every release of owner g, `ptr` becomes (g+1) mod `Inputs`.
- `ARB_IDLE`:
  - If any `req_valid` is high, pick the winner by priority search.
  - Next cycle: state becomes `ARB_LOCKED`, `grant[winner]` is set and `grant_index` equals the winner.
  - Otherwise, remain in `ARB_IDLE`.
- `ARB_LOCKED`, owner g:
  - `out_valid = req_valid[g]`
  - `out_last = req_last[g]`
  - `req_ready[g] = out_ready`
  - All other `req_ready` are 0.
  - A beat transfers when `req_valid[g] && out_ready`.
- Release happens on a transfer with `req_last[g]` set:
  - Re-arbitrate in the same cycle over `req_valid` with g masked out, searching from (g+1) mod `Inputs`.
  - Hit: the new grant loads next cycle and the state stays `ARB_LOCKED`, so there is no bubble.
  - Miss: go to `ARB_IDLE`.
- Grant is held regardless of `out_ready` stalls or of the owner dropping `req_valid` mid-packet. Only a last-beat transfer or `rst` releases it.
- `Inputs` = 1: `grant[0]` follows the same FSM; `ptr` stays 0.
- Outputs in `ARB_IDLE`: `out_valid`, `out_last`, all `req_ready` and all `grant` bits are 0.

## Timing
- Reset values: state `ARB_IDLE`, `ptr` 0, all `grant` 0, `grant_index` 0, `out_valid` 0, `out_last` 0, all `req_ready` 0.
- Reset mid-packet: the grant drops at the next edge. No release bookkeeping occurs and `ptr` is forced to 0.
- Latency:
  - From idle, a request at cycle N produces `grant` at cycle N+1; the first transfer is possible at N+1.
  - A release at cycle N hands the grant to the next owner at cycle N+1, giving 1 beat per cycle across owners.
- `grant` and `grant_index` are registered.
- `req_ready`, `out_valid` and `out_last` are combinational from registered `grant` plus `out_ready`, `req_valid` and `req_last`. There is no combinational path from `req_valid` to `grant`.
- Requesters follow valid/ready rules: once `req_valid[i]` is asserted, it and `req_last[i]` stay stable until accepted. The arbiter tolerates violations as described above.

## Structure
- Shared package `arb_pkg` holds:
  - `typedef enum logic {ARB_IDLE, ARB_LOCKED} arb_state_e`
  - Helper function `arb_idx_width(int n)` returning `(n > 1) ? $clog2(n) : 1`.
- Sub-module `rr_pick` is combinational:
  - Inputs: request vector, start pointer and exclude mask.
  - Outputs: one-hot winner, winner index and `any`.
  - It is instantiated once and reused for both the idle and release arbitration paths.
- The data mux is instantiated by the parent, with `grant` wired to its `sel`.

## Test plan
- Reset, `Inputs`=4, no requests: `grant` = 0000, `grant_index` = 0, `out_valid` = 0, all `req_ready` = 0 for 10 cycles.
- Single request, single beat:
  - Stimulus: `req_valid[2]` with last at cycle 0, `out_ready`=1.
  - Required: `grant[2]` at cycle 1 with the transfer at cycle 1; `grant` = 0000 at cycle 2; a later simultaneous request from 2 and 3 grants 3.
- All four requesting continuous single-beat packets with `out_ready`=1: grants 0,1,2,3,0,1 on consecutive cycles from cycle 1, with no idle cycles.
- Multi-beat packet with stall:
  - Stimulus: requester 1 sends a 3-beat packet, `out_ready` is low for 2 cycles after beat 1, and requester 0 requests throughout.
  - Required: `grant[1]` is held for 5 cycles; `grant[0]` is asserted the cycle after the last beat.
- Exclusion at release:
  - Stimulus: owner 3 releases while `req_valid[3]` and `req_valid[1]` are high.
  - Required: next grant is 1, not 3.
- Reset mid-packet:
  - Stimulus: `rst` pulsed while `grant[2]` is held.
  - Required: `grant` = 0000 next cycle; afterward, simultaneous requests from 0 and 3 grant 0.

Source files
------------

// File: rtl/arb_pkg.sv
// arb_pkg: shared types and helpers for the round-robin arbiter.
// Imported by rr_pick and rr_arbiter.
package arb_pkg;

    typedef enum logic {
        ARB_IDLE   = 1'b0,
        ARB_LOCKED = 1'b1
    } arb_state_e;

    function automatic int arb_idx_width(int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/rr_pick.sv
// rr_pick: combinational round-robin priority search.
// Finds the first requester at or after start, wrapping, skipping excl.
module rr_pick
    import arb_pkg::*;
#(
    parameter int N = 4,
    parameter int W = arb_idx_width(N)
) (
    input  logic [N-1:0] req,
    input  logic [W-1:0] start,
    input  logic [N-1:0] excl,
    output logic [N-1:0] win,
    output logic [W-1:0] win_idx,
    output logic         any
);

    logic [N-1:0] cand;
    logic [W-1:0] jj;

    // Walk the ring from start and keep the first eligible requester
    always_comb begin
        cand    = req & ~excl;
        win     = '0;
        win_idx = '0;
        any     = 1'b0;
        jj      = '0;
        for (int k = 0; k < N; k++) begin
            jj = W'((int'(start) + k) % N);
            if (!any && cand[jj]) begin
                win[jj] = 1'b1;
                win_idx = jj;
                any     = 1'b1;
            end
        end
    end

endmodule

// File: rtl/rr_arbiter.sv
// rr_arbiter: packet-locking round-robin arbiter with registered one-hot grant.
// The grant is held until the owner's last beat transfers or reset.
module rr_arbiter
    import arb_pkg::*;
#(
    parameter int Inputs   = 4,
    parameter int IdxWidth = arb_idx_width(Inputs)
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [Inputs-1:0]   req_valid,
    input  logic [Inputs-1:0]   req_last,
    output logic [Inputs-1:0]   req_ready,
    output logic [Inputs-1:0]   grant,
    output logic [IdxWidth-1:0] grant_index,
    output logic                out_valid,
    output logic                out_last,
    input  logic                out_ready
);

    arb_state_e          state_q, state_d;
    logic [Inputs-1:0]   grant_q, grant_d;
    logic [IdxWidth-1:0] gidx_q, gidx_d;
    logic [IdxWidth-1:0] ptr_q, ptr_d;
    logic [IdxWidth-1:0] nxt_idx;
    logic [IdxWidth-1:0] pick_start;
    logic [Inputs-1:0]   pick_excl;
    logic [Inputs-1:0]   pick_win;
    logic [IdxWidth-1:0] pick_idx;
    logic                pick_any;
    logic                locked;
    logic                owner_valid;
    logic                owner_last;
    logic                rel_fire;

    // Downstream view is the owner's request, gated by the registered grant
    always_comb begin
        owner_valid = |(req_valid & grant_q);
        owner_last  = |(req_last & grant_q);
        out_valid   = owner_valid;
        out_last    = owner_last;
        req_ready   = grant_q & {Inputs{out_ready}};
    end

    // Search window: from ptr when idle, from owner+1 without owner on release
    always_comb begin
        locked     = (state_q == ARB_LOCKED);
        nxt_idx    = IdxWidth'((int'(gidx_q) + 1) % Inputs);
        pick_start = locked ? nxt_idx : ptr_q;
        pick_excl  = locked ? grant_q : '0;
        rel_fire   = locked && owner_valid && owner_last && out_ready;
    end

    rr_pick #(
        .N (Inputs),
        .W (IdxWidth)
    ) u_pick (
        .req     (req_valid),
        .start   (pick_start),
        .excl    (pick_excl),
        .win     (pick_win),
        .win_idx (pick_idx),
        .any     (pick_any)
    );

    // Next-state: grant on idle request, hand over or drop on last beat
    always_comb begin
        state_d = state_q;
        grant_d = grant_q;
        gidx_d  = gidx_q;
        ptr_d   = ptr_q;
        unique case (state_q)
            ARB_IDLE: begin
                if (pick_any) begin
                    state_d = ARB_LOCKED;
                    grant_d = pick_win;
                    gidx_d  = pick_idx;
                end
            end
            ARB_LOCKED: begin
                if (rel_fire) begin
                    ptr_d = nxt_idx;
                    if (pick_any) begin
                        grant_d = pick_win;
                        gidx_d  = pick_idx;
                    end else begin
                        state_d = ARB_IDLE;
                        grant_d = '0;
                        gidx_d  = '0;
                    end
                end
            end
        endcase
    end

    // State, grant and pointer registers with synchronous reset
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ARB_IDLE;
            grant_q <= '0;
            gidx_q  <= '0;
            ptr_q   <= '0;
        end else begin
            state_q <= state_d;
            grant_q <= grant_d;
            gidx_q  <= gidx_d;
            ptr_q   <= ptr_d;
        end
    end

    assign grant       = grant_q;
    assign grant_index = gidx_q;

endmodule
